// File: rtl/imm_pkg.sv
// Shared opcode constants, instruction-format codes and skid-buffer states
// for the immediate generator.
package imm_pkg;

  localparam logic [6:0] LOAD      = 7'h03;
  localparam logic [6:0] MISC_MEM  = 7'h0F;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_IMM_32 = 7'h1B;
  localparam logic [6:0] AUIPC     = 7'h17;
  localparam logic [6:0] STORE     = 7'h23;
  localparam logic [6:0] OP        = 7'h33;
  localparam logic [6:0] LUI       = 7'h37;
  localparam logic [6:0] OP_32     = 7'h3B;
  localparam logic [6:0] BRANCH    = 7'h63;
  localparam logic [6:0] JALR      = 7'h67;
  localparam logic [6:0] JAL       = 7'h6F;
  localparam logic [6:0] SYSTEM    = 7'h73;

  typedef enum logic [2:0] {
    FMT_R       = 3'd0,
    FMT_I       = 3'd1,
    FMT_S       = 3'd2,
    FMT_B       = 3'd3,
    FMT_U       = 3'd4,
    FMT_J       = 3'd5,
    FMT_SHAMT   = 3'd6,
    FMT_ILLEGAL = 3'd7
  } imm_fmt_e;

  typedef enum logic [1:0] {
    SK_EMPTY = 2'd0,
    SK_ONE   = 2'd1,
    SK_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32/RV64 immediate decode: instruction + PC -> immediate, target, format.
// IMM_ILLEGAL_EN selects whether unknown opcodes are flagged illegal or decode as R.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] target_o,
  output imm_fmt_e        fmt_o,
  output logic            illegal_o
);

  localparam bit RV64 = (XLEN == 64);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_shift;
  logic       known;
  logic       pc_rel;

  assign opcode   = instr_i[6:0];
  assign funct3   = instr_i[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    fmt_o     = FMT_R;
    imm_o     = '0;
    known     = 1'b1;
    illegal_o = 1'b0;
    case (opcode)
      LOAD, MISC_MEM, JALR, SYSTEM: begin
        fmt_o = FMT_I;
        imm_o = XLEN'($signed(instr_i[31:20]));
      end
      OP_IMM, OP_IMM_32: begin
        if ((opcode == OP_IMM_32) && !RV64) begin
          known = 1'b0;
        end else if (is_shift) begin
          // Only RV64 OP-IMM has a 6-bit shamt; the W forms stay at 5 bits.
          fmt_o = FMT_SHAMT;
          if ((opcode == OP_IMM) && RV64) imm_o = XLEN'(instr_i[25:20]);
          else                            imm_o = XLEN'(instr_i[24:20]);
        end else begin
          fmt_o = FMT_I;
          imm_o = XLEN'($signed(instr_i[31:20]));
        end
      end
      STORE: begin
        fmt_o = FMT_S;
        imm_o = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
      end
      BRANCH: begin
        fmt_o = FMT_B;
        imm_o = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                               instr_i[11:8], 1'b0}));
      end
      LUI, AUIPC: begin
        fmt_o = FMT_U;
        imm_o = XLEN'($signed({instr_i[31:12], 12'b0}));
      end
      JAL: begin
        fmt_o = FMT_J;
        imm_o = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                               instr_i[30:21], 1'b0}));
      end
      OP: begin
        fmt_o = FMT_R;
      end
      OP_32: begin
        if (!RV64) known = 1'b0;
      end
      default: begin
        known = 1'b0;
      end
    endcase

    if (!known) begin
      imm_o = '0;
`ifdef IMM_ILLEGAL_EN
      fmt_o     = FMT_ILLEGAL;
      illegal_o = 1'b1;
`else
      fmt_o     = FMT_R;
      illegal_o = 1'b0;
`endif
    end
  end

  // JALR is excluded: its base is rs1, which is not available at decode.
  assign pc_rel   = (fmt_o == FMT_B) || (fmt_o == FMT_J) || (opcode == AUIPC);
  assign target_o = pc_rel ? (pc_i + imm_o) : '0;

endmodule

// File: rtl/immediate_gen_pipe.sv
// Pipelined immediate generator: imm_decode followed by a 2-entry skid buffer
// (SKID=1) or a single output register (SKID=0). Build option: IMM_ILLEGAL_EN.
//
// state    | meaning
// SK_EMPTY | no result held, out_valid_o low
// SK_ONE   | one result on the output (entry 0)
// SK_FULL  | entry 0 on the output, entry 1 queued behind it, in_ready_o low
module immediate_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] target_o,
  output logic [2:0]      fmt_o,
  output logic            illegal_o
);

  localparam int PW = 2 * XLEN + 4;

  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] dec_target;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;
  logic [PW-1:0]   dec_pl;

  logic [PW-1:0]   head_pl;
  logic            head_valid;
  logic            rdy_int;
  logic            in_fire;
  logic            out_fire;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr_i   (instr_i),
    .pc_i      (pc_i),
    .imm_o     (dec_imm),
    .target_o  (dec_target),
    .fmt_o     (dec_fmt),
    .illegal_o (dec_illegal)
  );

  assign dec_pl = {dec_imm, dec_target, dec_fmt, dec_illegal};

  // Reset masks the handshake so nothing transfers on the reset edge.
  assign in_ready_o  = rdy_int & ~reset;
  assign out_valid_o = head_valid & ~reset;
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;

  assign {imm_o, target_o, fmt_o, illegal_o} = reset ? '0 : head_pl;

  generate
    if (SKID != 0) begin : g_skid
      skid_state_e   state_q, state_d;
      logic [PW-1:0] e0_q, e0_d;
      logic [PW-1:0] e1_q, e1_d;
      logic          rdy_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          state_q <= SK_EMPTY;
          e0_q    <= '0;
          e1_q    <= '0;
          rdy_q   <= 1'b1;
        end else begin
          state_q <= state_d;
          e0_q    <= e0_d;
          e1_q    <= e1_d;
          rdy_q   <= (state_d != SK_FULL);
        end
      end

      always_comb begin
        state_d = state_q;
        e0_d    = e0_q;
        e1_d    = e1_q;
        case (state_q)
          SK_EMPTY: begin
            if (in_fire) begin
              e0_d    = dec_pl;
              state_d = SK_ONE;
            end
          end
          SK_ONE: begin
            if (in_fire && out_fire) begin
              e0_d = dec_pl;
            end else if (in_fire) begin
              e1_d    = dec_pl;
              state_d = SK_FULL;
            end else if (out_fire) begin
              state_d = SK_EMPTY;
            end
          end
          SK_FULL: begin
            if (out_fire) begin
              e0_d    = e1_q;
              state_d = SK_ONE;
            end
          end
          default: begin
            state_d = SK_EMPTY;
          end
        endcase
      end

      assign head_valid = (state_q != SK_EMPTY);
      assign head_pl    = e0_q;
      assign rdy_int    = rdy_q;
    end else begin : g_reg
      logic          valid_q, valid_d;
      logic [PW-1:0] pl_q, pl_d;

      always_ff @(posedge clk) begin
        if (reset) begin
          valid_q <= 1'b0;
          pl_q    <= '0;
        end else begin
          valid_q <= valid_d;
          pl_q    <= pl_d;
        end
      end

      always_comb begin
        valid_d = valid_q;
        pl_d    = pl_q;
        if (in_fire) begin
          valid_d = 1'b1;
          pl_d    = dec_pl;
        end else if (out_fire) begin
          valid_d = 1'b0;
        end
      end

      assign head_valid = valid_q;
      assign head_pl    = pl_q;
      assign rdy_int    = !valid_q || out_ready_i;
    end
  endgenerate

endmodule

// File: tb/tb_immediate_gen_pipe.sv
// Bench for immediate_gen_pipe: an RV32/SKID=1 and an RV64/SKID=0 instance on
// shared stimulus, checked against a behavioural decode model and FIFO scoreboards.
module tb_immediate_gen_pipe;

`ifdef IMM_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif
  localparam bit [2:0] FX = ILL_EN ? 3'd7 : 3'd0;
  localparam bit       LX = ILL_EN;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [63:0] pc64;
  logic [31:0] pc32;

  logic        r32_in_ready, r32_out_valid, r32_ill;
  logic [31:0] r32_imm, r32_tgt;
  logic [2:0]  r32_fmt;
  logic        r64_in_ready, r64_out_valid, r64_ill;
  logic [63:0] r64_imm, r64_tgt;
  logic [2:0]  r64_fmt;

  int n_chk  = 0;
  int n_pass = 0;

  assign pc32 = pc64[31:0];

  always #5 clk = ~clk;

  immediate_gen_pipe #(.XLEN(32), .SKID(1)) dut32 (
    .clk(clk), .reset(reset), .in_valid_i(in_valid), .in_ready_o(r32_in_ready),
    .instr_i(instr), .pc_i(pc32), .out_valid_o(r32_out_valid), .out_ready_i(out_ready),
    .imm_o(r32_imm), .target_o(r32_tgt), .fmt_o(r32_fmt), .illegal_o(r32_ill)
  );

  immediate_gen_pipe #(.XLEN(64), .SKID(0)) dut64 (
    .clk(clk), .reset(reset), .in_valid_i(in_valid), .in_ready_o(r64_in_ready),
    .instr_i(instr), .pc_i(pc64), .out_valid_o(r64_out_valid), .out_ready_i(out_ready),
    .imm_o(r64_imm), .target_o(r64_tgt), .fmt_o(r64_fmt), .illegal_o(r64_ill)
  );

  typedef struct packed {
    bit [63:0] imm;
    bit [63:0] tgt;
    bit [2:0]  fmt;
    bit        ill;
  } exp_t;

  typedef struct packed {
    bit [31:0] ins;
    bit [63:0] pc;
    bit [31:0] i32;
    bit [31:0] t32;
    bit [2:0]  f32;
    bit        l32;
    bit [63:0] i64;
    bit [63:0] t64;
    bit [2:0]  f64;
    bit        l64;
  } dvec_t;

  exp_t q32[$];
  exp_t q64[$];

  // Two's-complement sign extension of a 'bits'-wide value held in v.
  function automatic bit [63:0] sx(bit [63:0] v, int bits);
    bit [63:0] s;
    s = 64'd1 << (bits - 1);
    return (v ^ s) - s;
  endfunction

  function automatic exp_t model(bit [31:0] ins, bit [63:0] pc, int xlen);
    exp_t      e;
    bit [6:0]  op;
    bit [2:0]  f3;
    bit        rv64;
    bit        known;
    bit [63:0] m;
    e     = '0;
    op    = ins[6:0];
    f3    = ins[14:12];
    rv64  = (xlen == 64);
    known = 1'b1;
    m     = rv64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    case (op)
      7'h03, 7'h0F, 7'h67, 7'h73: begin
        e.fmt = 3'd1; e.imm = sx(64'(ins[31:20]), 12);
      end
      7'h13, 7'h1B: begin
        if (op == 7'h1B && !rv64) known = 1'b0;
        else if (f3 == 3'd1 || f3 == 3'd5) begin
          e.fmt = 3'd6;
          e.imm = (op == 7'h13 && rv64) ? 64'(ins[25:20]) : 64'(ins[24:20]);
        end else begin
          e.fmt = 3'd1; e.imm = sx(64'(ins[31:20]), 12);
        end
      end
      7'h23: begin e.fmt = 3'd2; e.imm = sx(64'({ins[31:25], ins[11:7]}), 12); end
      7'h63: begin
        e.fmt = 3'd3;
        e.imm = sx(64'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13);
      end
      7'h37, 7'h17: begin e.fmt = 3'd4; e.imm = sx(64'({ins[31:12], 12'h000}), 32); end
      7'h6F: begin
        e.fmt = 3'd5;
        e.imm = sx(64'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21);
      end
      7'h33: e.fmt = 3'd0;
      7'h3B: if (!rv64) known = 1'b0;
      default: known = 1'b0;
    endcase
    if (!known) begin
      e.imm = 64'd0;
      e.fmt = ILL_EN ? 3'd7 : 3'd0;
      e.ill = ILL_EN;
    end
    e.imm = e.imm & m;
    if (e.fmt == 3'd3 || e.fmt == 3'd5 || op == 7'h17) e.tgt = ((pc & m) + e.imm) & m;
    return e;
  endfunction

  function automatic bit [31:0] rand_instr();
    bit [6:0]  ops [13] = '{7'h03, 7'h0F, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23,
                            7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B};
    bit [31:0] r;
    bit [6:0]  op;
    r = $urandom;
    if (r[2:0] == 3'd0) op = 7'($urandom);
    else                op = ops[$urandom_range(12)];
    return {r[31:7], op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; instr = '0; pc64 = '0;
    repeat (3) tick();
    @(negedge clk);
    n_chk++;
    if ({r32_out_valid, r32_in_ready, r64_out_valid, r64_in_ready} !== 4'b0000)
      $display("FAIL reset_handshake: got %b want 0000",
               {r32_out_valid, r32_in_ready, r64_out_valid, r64_in_ready});
    else n_pass++;
    n_chk++;
    if ({r32_imm, r32_tgt, r32_fmt, r32_ill, r64_imm, r64_tgt, r64_fmt, r64_ill} !== '0)
      $display("FAIL reset_payload: got imm32=%h fmt32=%0d imm64=%h fmt64=%0d want all 0",
               r32_imm, r32_fmt, r64_imm, r64_fmt);
    else n_pass++;
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({r32_in_ready, r64_in_ready, r32_out_valid, r64_out_valid} !== 4'b1100)
      $display("FAIL reset_release: got rdy32/rdy64/vld32/vld64=%b want 1100",
               {r32_in_ready, r64_in_ready, r32_out_valid, r64_out_valid});
    else n_pass++;
  endtask

  task automatic test_directed();
    dvec_t v[$];
    v.push_back('{32'hFFF00093, 64'h0, 32'hFFFFFFFF, 32'h0, 3'd1, 1'b0,
                  64'hFFFFFFFF_FFFFFFFF, 64'h0, 3'd1, 1'b0});
    v.push_back('{32'h12345037, 64'h0, 32'h12345000, 32'h0, 3'd4, 1'b0,
                  64'h12345000, 64'h0, 3'd4, 1'b0});
    v.push_back('{32'hFFFFF037, 64'h0, 32'hFFFFF000, 32'h0, 3'd4, 1'b0,
                  64'hFFFFFFFF_FFFFF000, 64'h0, 3'd4, 1'b0});
    v.push_back('{32'hFE000EE3, 64'h100, 32'hFFFFFFFC, 32'hFC, 3'd3, 1'b0,
                  64'hFFFFFFFF_FFFFFFFC, 64'hFC, 3'd3, 1'b0});
    v.push_back('{32'h0080006F, 64'hFFFFFFFF_FFFFFFFC, 32'h8, 32'h4, 3'd5, 1'b0,
                  64'h8, 64'h4, 3'd5, 1'b0});
    v.push_back('{32'h4030D093, 64'h0, 32'h3, 32'h0, 3'd6, 1'b0, 64'h3, 64'h0, 3'd6, 1'b0});
    v.push_back('{32'h0000007F, 64'h40, 32'h0, 32'h0, FX, LX, 64'h0, 64'h0, FX, LX});
    v.push_back('{32'h0010009B, 64'h0, 32'h0, 32'h0, FX, LX, 64'h1, 64'h0, 3'd1, 1'b0});
    v.push_back('{32'h4200D09B, 64'h0, 32'h0, 32'h0, FX, LX, 64'h0, 64'h0, 3'd6, 1'b0});
    v.push_back('{32'h02009093, 64'h0, 32'h0, 32'h0, 3'd6, 1'b0, 64'h20, 64'h0, 3'd6, 1'b0});
    v.push_back('{32'hFE112E23, 64'h0, 32'hFFFFFFFC, 32'h0, 3'd2, 1'b0,
                  64'hFFFFFFFF_FFFFFFFC, 64'h0, 3'd2, 1'b0});
    v.push_back('{32'h00008067, 64'h500, 32'h0, 32'h0, 3'd1, 1'b0, 64'h0, 64'h0, 3'd1, 1'b0});
    v.push_back('{32'h00001017, 64'h1000, 32'h1000, 32'h2000, 3'd4, 1'b0,
                  64'h1000, 64'h2000, 3'd4, 1'b0});
    v.push_back('{32'h00000033, 64'h1234, 32'h0, 32'h0, 3'd0, 1'b0, 64'h0, 64'h0, 3'd0, 1'b0});
    v.push_back('{32'h0000003B, 64'h0, 32'h0, 32'h0, FX, LX, 64'h0, 64'h0, 3'd0, 1'b0});
    foreach (v[i]) begin
      tick();
      in_valid = 1'b1; out_ready = 1'b1; instr = v[i].ins; pc64 = v[i].pc;
      @(negedge clk);
      n_chk++;
      if ({r32_in_ready, r64_in_ready} !== 2'b11)
        $display("FAIL dir_accept[%0d]: got rdy32/rdy64=%b want 11", i,
                 {r32_in_ready, r64_in_ready});
      else n_pass++;
      tick();
      in_valid = 1'b0; instr = 32'h0;
      @(negedge clk);
      n_chk++;
      if ({r32_out_valid, r32_fmt, r32_ill, r32_imm, r32_tgt} !==
          {1'b1, v[i].f32, v[i].l32, v[i].i32, v[i].t32})
        $display("FAIL dir32[%0d] instr %h: got vld=%b fmt=%0d ill=%b imm=%h tgt=%h want vld=1 fmt=%0d ill=%b imm=%h tgt=%h",
                 i, v[i].ins, r32_out_valid, r32_fmt, r32_ill, r32_imm, r32_tgt,
                 v[i].f32, v[i].l32, v[i].i32, v[i].t32);
      else n_pass++;
      n_chk++;
      if ({r64_out_valid, r64_fmt, r64_ill, r64_imm, r64_tgt} !==
          {1'b1, v[i].f64, v[i].l64, v[i].i64, v[i].t64})
        $display("FAIL dir64[%0d] instr %h: got vld=%b fmt=%0d ill=%b imm=%h tgt=%h want vld=1 fmt=%0d ill=%b imm=%h tgt=%h",
                 i, v[i].ins, r64_out_valid, r64_fmt, r64_ill, r64_imm, r64_tgt,
                 v[i].f64, v[i].l64, v[i].i64, v[i].t64);
      else n_pass++;
    end
    tick();
  endtask

  task automatic test_random_stream();
    exp_t        e;
    bit          hold32, hold64;
    bit [67:0]   held32;
    bit [131:0]  held64;
    hold32 = 1'b0; hold64 = 1'b0; held32 = '0; held64 = '0;
    q32.delete(); q64.delete();
    for (int cyc = 0; cyc < 620; cyc++) begin
      if (cyc < 600) begin
        in_valid  = ($urandom_range(3) != 0);
        out_ready = ($urandom_range(2) != 0);
        instr     = rand_instr();
        pc64      = {$urandom, $urandom};
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (hold32) begin
        n_chk++;
        if ({r32_out_valid, r32_fmt, r32_ill, r32_imm, r32_tgt} !== {1'b1, held32})
          $display("FAIL hold32: got vld=%b payload=%h want vld=1 payload=%h",
                   r32_out_valid, {r32_fmt, r32_ill, r32_imm, r32_tgt}, held32);
        else n_pass++;
      end
      if (hold64) begin
        n_chk++;
        if ({r64_out_valid, r64_fmt, r64_ill, r64_imm, r64_tgt} !== {1'b1, held64})
          $display("FAIL hold64: got vld=%b payload=%h want vld=1 payload=%h",
                   r64_out_valid, {r64_fmt, r64_ill, r64_imm, r64_tgt}, held64);
        else n_pass++;
      end
      hold32 = r32_out_valid && !out_ready;
      held32 = {r32_fmt, r32_ill, r32_imm, r32_tgt};
      hold64 = r64_out_valid && !out_ready;
      held64 = {r64_fmt, r64_ill, r64_imm, r64_tgt};
      if (r32_out_valid && out_ready) begin
        n_chk++;
        if (q32.size() == 0) $display("FAIL rand32_extra: got unexpected output imm=%h want none", r32_imm);
        else begin
          e = q32.pop_front();
          if ({r32_fmt, r32_ill, r32_imm, r32_tgt} !== {e.fmt, e.ill, e.imm[31:0], e.tgt[31:0]})
            $display("FAIL rand32: got fmt=%0d ill=%b imm=%h tgt=%h want fmt=%0d ill=%b imm=%h tgt=%h",
                     r32_fmt, r32_ill, r32_imm, r32_tgt, e.fmt, e.ill, e.imm[31:0], e.tgt[31:0]);
          else n_pass++;
        end
      end
      if (r64_out_valid && out_ready) begin
        n_chk++;
        if (q64.size() == 0) $display("FAIL rand64_extra: got unexpected output imm=%h want none", r64_imm);
        else begin
          e = q64.pop_front();
          if ({r64_fmt, r64_ill, r64_imm, r64_tgt} !== {e.fmt, e.ill, e.imm, e.tgt})
            $display("FAIL rand64: got fmt=%0d ill=%b imm=%h tgt=%h want fmt=%0d ill=%b imm=%h tgt=%h",
                     r64_fmt, r64_ill, r64_imm, r64_tgt, e.fmt, e.ill, e.imm, e.tgt);
          else n_pass++;
        end
      end
      if (in_valid && r32_in_ready) q32.push_back(model(instr, {32'h0, pc32}, 32));
      if (in_valid && r64_in_ready) q64.push_back(model(instr, pc64, 64));
      tick();
    end
    n_chk++;
    if ({q32.size(), q64.size()} !== {32'd0, 32'd0})
      $display("FAIL rand_drain: got left32=%0d left64=%0d want 0 0", q32.size(), q64.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    bit [31:0] bi [4];
    bit [63:0] bp [4];
    exp_t      e;
    int        k, seen, cyc;
    for (int i = 0; i < 4; i++) begin
      bi[i] = rand_instr();
      bp[i] = {$urandom, $urandom};
    end
    k = 0; seen = 0; cyc = 0;
    while (cyc < 40 && seen < 4) begin
      out_ready = (cyc >= 4);
      in_valid  = (k < 4);
      instr     = bi[k % 4];
      pc64      = bp[k % 4];
      @(negedge clk);
      if (r32_out_valid && out_ready) begin
        e = model(bi[seen], {32'h0, bp[seen][31:0]}, 32);
        n_chk++;
        if ({r32_fmt, r32_ill, r32_imm, r32_tgt} !== {e.fmt, e.ill, e.imm[31:0], e.tgt[31:0]})
          $display("FAIL bp_order[%0d]: got fmt=%0d imm=%h tgt=%h want fmt=%0d imm=%h tgt=%h",
                   seen, r32_fmt, r32_imm, r32_tgt, e.fmt, e.imm[31:0], e.tgt[31:0]);
        else n_pass++;
        seen++;
      end
      if (in_valid && r32_in_ready) k++;
      if (cyc == 3) begin
        n_chk++;
        if ({k, r32_in_ready, r32_out_valid} !== {32'd2, 1'b0, 1'b1})
          $display("FAIL bp_stall: got accepted=%0d rdy=%b vld=%b want accepted=2 rdy=0 vld=1",
                   k, r32_in_ready, r32_out_valid);
        else n_pass++;
      end
      tick();
      cyc++;
    end
    n_chk++;
    if (seen !== 4) $display("FAIL bp_count: got %0d results want 4", seen);
    else n_pass++;
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; instr = rand_instr(); pc64 = {$urandom, $urandom};
      tick();
    end
    reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({r32_out_valid, r32_in_ready, r32_imm, r32_fmt} !== '0)
      $display("FAIL rst_mid_during: got vld=%b rdy=%b imm=%h fmt=%0d want all 0",
               r32_out_valid, r32_in_ready, r32_imm, r32_fmt);
    else n_pass++;
    tick();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({r32_out_valid, r32_in_ready, r64_out_valid, r64_in_ready} !== 4'b0101)
      $display("FAIL rst_mid_after: got vld32/rdy32/vld64/rdy64=%b want 0101",
               {r32_out_valid, r32_in_ready, r64_out_valid, r64_in_ready});
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      n_chk++;
      if ({r32_out_valid, r64_out_valid} !== 2'b00)
        $display("FAIL rst_mid_dropped[%0d]: got vld32/vld64=%b want 00", i,
                 {r32_out_valid, r64_out_valid});
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_stream();
    test_backpressure();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish within 500000 time units want finish");
    $fatal(1, "timeout");
  end

endmodule
